// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional hit/mispredict statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        update_mispredict,
    output logic [31:0] btb_target_pc,
    output logic        btb_pc_valid,
    output logic        btb_pc_predictTaken
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         cnt_q    [ENTRIES];
    logic [1:0]         cnt_d    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, up_act;
    logic             unused_bits;

    assign lk_idx      = pc[IDX+1:2];
    assign lk_tag      = pc[31:IDX+2];
    assign up_idx      = update_pc[IDX+1:2];
    assign up_tag      = update_pc[31:IDX+2];
    assign unused_bits = ^{pc[1:0], update_pc[1:0], update_mispredict};

    // Lookup sees the pre-edge table contents, so a same-cycle update is visible next cycle.
    always_comb begin
        lk_hit              = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        btb_pc_valid        = lk_hit;
        btb_target_pc       = lk_hit ? target_q[lk_idx] : 32'd0;
        btb_pc_predictTaken = lk_hit && cnt_q[lk_idx][1];
    end

    // Updates are suppressed while reset is held.
    assign up_act = update_en && rst;
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (up_act) begin
            if (up_hit) begin
                if (update_taken) begin
                    cnt_d[up_idx]    = ctr_inc(cnt_q[up_idx]);
                    target_d[up_idx] = update_target;
                end else begin
                    cnt_d[up_idx] = ctr_dec(cnt_q[up_idx]);
                end
            end else if (update_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = update_target;
                cnt_d[up_idx]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CTR_WNT;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tag and target are don't-care while the valid bit is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BTB_STATS_EN
    logic [31:0] hits_q, hits_d, misp_q, misp_d;

    always_comb begin
        hits_d = hits_q;
        misp_d = misp_q;
        if (lk_hit && (hits_q != 32'hFFFF_FFFF)) hits_d = hits_q + 32'd1;
        if (update_en && update_mispredict && (misp_q != 32'hFFFF_FFFF)) misp_d = misp_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q <= '0;
            misp_q <= '0;
        end else begin
            hits_q <= hits_d;
            misp_q <= misp_d;
        end
    end

    assign stat_hits        = hits_q;
    assign stat_mispredicts = misp_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized bench for branch_target_buffer against a table-level reference model.
// Define BTB_STATS_EN for both bench and design to cover the statistics counters.
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int IDX     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        update_mispredict;
    logic [31:0] btb_target_pc;
    logic        btb_pc_valid;
    logic        btb_pc_predictTaken;
`ifdef BTB_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;
`endif

    branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc                  (pc),
        .update_en           (update_en),
        .update_pc           (update_pc),
        .update_target       (update_target),
        .update_taken        (update_taken),
        .update_mispredict   (update_mispredict),
        .btb_target_pc       (btb_target_pc),
        .btb_pc_valid        (btb_pc_valid),
        .btb_pc_predictTaken (btb_pc_predictTaken)
`ifdef BTB_STATS_EN
        ,
        .stat_hits           (stat_hits),
        .stat_mispredicts    (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-slot owner line, target and a 0..3 confidence level.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_owner  [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_level  [ENTRIES];
    longint      m_hits;
    longint      m_misp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] line(input logic [31:0] a);
        return a >> (IDX + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_owner[slot(a)] == line(a));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_level[i] = 1;
        end
        m_hits = 0;
        m_misp = 0;
    endtask

    task automatic model_update();
        int s;
        s = slot(update_pc);
        if (m_hit(update_pc)) begin
            if (update_taken) begin
                m_level[s]  = (m_level[s] < 3) ? m_level[s] + 1 : 3;
                m_target[s] = update_target;
            end else begin
                m_level[s] = (m_level[s] > 0) ? m_level[s] - 1 : 0;
            end
        end else if (update_taken) begin
            m_valid[s]  = 1'b1;
            m_owner[s]  = line(update_pc);
            m_target[s] = update_target;
            m_level[s]  = 2;
        end
    endtask

    // Check the lookup mid-cycle, then advance one edge and mirror it in the model.
    task automatic cycle();
        bit h;
        @(negedge clk);
        h = m_hit(pc);
        check("lk_valid",  {31'd0, btb_pc_valid},        {31'd0, h});
        check("lk_target", btb_target_pc,                h ? m_target[slot(pc)] : 32'd0);
        check("lk_taken",  {31'd0, btb_pc_predictTaken}, {31'd0, h && (m_level[slot(pc)] >= 2)});
        @(posedge clk);
        if (rst) begin
            if (h && m_hits < 64'hFFFF_FFFF) m_hits++;
            if (update_en && update_mispredict && m_misp < 64'hFFFF_FFFF) m_misp++;
            if (update_en) model_update();
        end
        #1;
    endtask

    task automatic look(input string tag, input bit v, input logic [31:0] t, input bit p);
        check({tag, "_valid"},  {31'd0, btb_pc_valid},        {31'd0, v});
        check({tag, "_target"}, btb_target_pc,                t);
        check({tag, "_taken"},  {31'd0, btb_pc_predictTaken}, {31'd0, p});
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
        update_en     = 1'b1;
        update_pc     = p;
        update_target = t;
        update_taken  = tk;
    endtask

    task automatic idle();
        update_en = 1'b0;
    endtask

    initial begin
        logic [31:0] tg;
        rst = 1'b1; pc = 32'h40; update_en = 1'b0; update_pc = '0;
        update_target = '0; update_taken = 1'b0; update_mispredict = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        look("in_rst", 1'b0, 32'd0, 1'b0);
        rst = 1'b1;

        // Cold lookup
        cycle();
        look("cold", 1'b0, 32'd0, 1'b0);

        // Allocation lands at weakly taken
        upd(32'h40, 32'h100, 1'b1);
        cycle();
        idle(); #1;
        look("alloc", 1'b1, 32'h100, 1'b1);

        // Two not-taken updates: down to SNT, target untouched, still valid
        upd(32'h40, 32'hDEAD_0000, 1'b0);
        cycle(); cycle();
        idle(); #1;
        look("nt2", 1'b1, 32'h100, 1'b0);

        // Three taken reach ST, a fourth must saturate (one not-taken then still predicts taken)
        upd(32'h40, 32'h100, 1'b1);
        cycle(); cycle(); cycle();
        idle(); #1;
        look("st", 1'b1, 32'h100, 1'b1);
        upd(32'h40, 32'h100, 1'b1);
        cycle();
        upd(32'h40, 32'h100, 1'b0);
        cycle();
        idle(); #1;
        look("sat_hi", 1'b1, 32'h100, 1'b1);

        // Same-cycle lookup and update
        upd(32'h40, 32'h200, 1'b1);
        #1;
        look("rw_pre", 1'b1, 32'h100, 1'b1);
        cycle();
        idle(); #1;
        look("rw_post", 1'b1, 32'h200, 1'b1);

        // Not-taken miss does not allocate
        pc = 32'h80;
        upd(32'h80, 32'h300, 1'b0);
        cycle();
        idle(); #1;
        look("nt_miss", 1'b0, 32'd0, 1'b0);

        // Conflict replacement at the same index
        upd(32'h440, 32'h500, 1'b1);
        cycle();
        idle();
        pc = 32'h40;  #1;
        look("conf_old", 1'b0, 32'd0, 1'b0);
        pc = 32'h440; #1;
        look("conf_new", 1'b1, 32'h500, 1'b1);

        // Asynchronous reset mid-cycle with 0x40 valid
        pc = 32'h40;
        upd(32'h40, 32'h100, 1'b1);
        update_mispredict = 1'b1;
        cycle();
        idle();
        update_mispredict = 1'b0;
        #1;
        look("pre_rst", 1'b1, 32'h100, 1'b1);
        #1 rst = 1'b0;
        model_reset();
        #1;
        look("rst_async", 1'b0, 32'd0, 1'b0);
`ifdef BTB_STATS_EN
        check("rst_hits", stat_hits, 32'd0);
        check("rst_misp", stat_mispredicts, 32'd0);
`endif
        upd(32'h40, 32'h900, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        idle(); #1;
        look("post_rst", 1'b0, 32'd0, 1'b0);

        // Update in the cycle reset releases takes effect at the next edge
        upd(32'h40, 32'h700, 1'b1);
        cycle();
        idle(); #1;
        look("rel_upd", 1'b1, 32'h700, 1'b1);

        // Randomized traffic over a small tag pool to force hits and conflicts
        for (int n = 0; n < 400; n++) begin
            tg = $urandom_range(0, 3);
            if (tg == 3) tg = 32'h00AB_CDE1;
            pc = (tg << (IDX + 2)) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
            tg = $urandom_range(0, 3);
            if (tg == 3) tg = 32'h00AB_CDE1;
            update_en         = ($urandom_range(0, 3) != 0);
            update_pc         = (tg << (IDX + 2)) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
            update_target     = $urandom;
            update_taken      = $urandom_range(0, 1);
            update_mispredict = $urandom_range(0, 1);
            cycle();
        end
        idle();
        update_mispredict = 1'b0;
`ifdef BTB_STATS_EN
        check("stat_hits", stat_hits, m_hits[31:0]);
        check("stat_misp", stat_mispredicts, m_misp[31:0]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter ENTRIES, default 16: number of direct-mapped entries; power of two, 4..64; IDX = log2(ENTRIES).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 pc  input  32  current fetch PC used for lookup.
REQ-005 update_en  input  1  resolved control-transfer information from execute is valid this cycle.
REQ-006 update_pc  input  32  PC of the resolved branch or jump.
REQ-007 update_target  input  32  resolved target address.
REQ-008 update_taken  input  1  resolved direction: 1 = taken.
REQ-009 update_mispredict  input  1  prediction for update_pc was wrong; used only for statistics.
REQ-010 btb_target_pc  output  32  predicted target for pc.
REQ-011 btb_pc_valid  output  1  pc hit a valid entry.
REQ-012 btb_pc_predictTaken  output  1  predict taken for pc.

Function
REQ-013 Index = pc[IDX+1:2]; tag = pc[31:IDX+2]; each entry holds valid, tag, a 32-bit target and a 2-bit counter.
REQ-014 Lookup is combinational, with zero-cycle latency from pc to outputs.
REQ-015 Hit = the indexed entry is valid and its tag equals the tag of pc.
REQ-016 On hit: btb_pc_valid=1; btb_target_pc = stored target; btb_pc_predictTaken = counter[1].
REQ-017 On miss: all three outputs are 0.
REQ-018 Counter states are SNT=00, WNT=01, WT=10, ST=11.
REQ-019 Taken moves the counter up one state, saturating at ST.
REQ-020 Not-taken moves the counter down one state, saturating at SNT.
REQ-021 Update hit (update_en=1, entry valid, tags match) with taken: step the counter and overwrite the target with update_target.
REQ-022 Update hit with not-taken: step the counter only; target and valid are unchanged, and the entry stays valid at SNT.
REQ-023 Update miss with taken: allocate the entry (valid=1, new tag, target=update_target, counter=WT), replacing any other tag at that index.
REQ-024 Update miss with not-taken: no state change.
REQ-025 Writes occur on the rising clk edge.
REQ-026 A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents, and the new contents are visible from the next cycle.
REQ-027 update_en=0: no table state changes, regardless of the other update inputs.
REQ-028 Untouched entries hold their state indefinitely.
REQ-029 No stall input; the fetch stage gates consumption of the outputs.

Reset
REQ-030 Assertion of rst immediately clears all valid bits and sets all counters to WNT; outputs go to 0 without waiting for a clock edge.
REQ-031 While rst is asserted, updates are ignored.
REQ-032 An update in the cycle rst deasserts takes effect normally at the next edge.
REQ-033 Tag and target storage need not be reset; no output may depend on them while the entry is invalid.

Configuration
REQ-034 Macro BTB_STATS_EN.
- Defined: adds outputs stat_hits (32 bits) and stat_mispredicts (32 bits).
- stat_hits increments each cycle the lookup hits.
- stat_mispredicts increments each cycle update_en and update_mispredict are both 1.
- Both counters saturate at 0xFFFFFFFF and clear to 0 on rst.
REQ-035 Macro undefined: the ports and counters do not exist and the remaining behaviour is identical.

Verification
REQ-036 Cold lookup: after reset, pc=0x00000040 -> valid=0, predictTaken=0, target=0.
REQ-037 Allocation and saturation:
- Update pc=0x40, target=0x100, taken=1 -> next cycle lookup 0x40 gives valid=1, target=0x100, predictTaken=1 (WT).
- Two further not-taken updates -> predictTaken=0 with valid=1.
- Three taken updates -> ST, and a fourth taken update stays at ST.
REQ-038 Conflict: with 0x40 allocated and ENTRIES=16, a taken update to pc=0x440 (same index, different tag) replaces the entry -> lookup 0x40 misses and lookup 0x440 hits.
REQ-039 Not-taken miss: update pc=0x80, taken=0 -> lookup 0x80 still misses.
REQ-040 Same-cycle read/write: lookup 0x40 while updating 0x40 with a new target 0x200 -> the same cycle shows 0x100 and the next cycle shows 0x200.
REQ-041 Mid-operation reset: assert rst asynchronously between edges with 0x40 valid -> outputs 0 immediately; after release, lookup 0x40 misses. With BTB_STATS_EN, the stat counters read 0.
